// File: rtl/lvds_sample_packer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : lvds_sample_packer
// Purpose  : Packs strobed LVDS receiver samples into WORD_BYTES-wide words
//            with a byte-keep mask and end-of-frame flag, then buffers them
//            in a small valid/ready FIFO for the capture/readout logic.
// Options  : PACKER_MSB_FIRST_EN - when defined, the first sample of a word
//            lands in the top lane (keep bits mirror the lanes).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module lvds_sample_packer #(
  parameter int DATA_W     = 8,
  parameter int WORD_BYTES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         Clock,
  input  logic                         Reset_n,
  input  logic                         Enable,
  input  logic [DATA_W-1:0]            DataIN,
  input  logic                         StrobIN,
  output logic [DATA_W*WORD_BYTES-1:0] WordOUT,
  output logic [WORD_BYTES-1:0]        KeepOUT,
  output logic                         LastOUT,
  output logic                         ValidOUT,
  input  logic                         ReadyIN,
  output logic                         Overflow,
  input  logic                         ClearOvf,
  output logic                         Busy
);

  localparam int c_WORD_W = DATA_W * WORD_BYTES;
  localparam int c_LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W  = c_PTR_W + 1;

  localparam logic [c_LANE_W-1:0] c_LANE_LAST = c_LANE_W'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  // Capture-side registers
  state_t                r_state, w_state_nxt;
  logic [c_LANE_W-1:0]   r_lane, w_lane_nxt;
  logic [c_WORD_W-1:0]   r_asm, w_asm_nxt;
  logic [WORD_BYTES-1:0] r_asm_keep, w_asm_keep_nxt;
  logic                  r_pend_vld, w_pend_vld_nxt;
  logic [c_WORD_W-1:0]   r_pend_word, w_pend_word_nxt;

  // Sample insertion into the word being assembled
  logic [c_LANE_W-1:0]   w_slot;
  logic [c_WORD_W-1:0]   w_ins_word;
  logic [WORD_BYTES-1:0] w_ins_keep;
  logic                  w_cap;

  // Push request toward the FIFO
  logic                  w_push;
  logic [c_WORD_W-1:0]   w_push_word;
  logic [WORD_BYTES-1:0] w_push_keep;
  logic                  w_push_last;

  // FIFO storage and control
  logic [c_WORD_W-1:0]   r_mem_word [FIFO_DEPTH];
  logic [WORD_BYTES-1:0] r_mem_keep [FIFO_DEPTH];
  logic                  r_mem_last [FIFO_DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;
  logic                  r_ovf;
  logic                  w_nonempty, w_full, w_pop, w_accept, w_drop;

`ifdef PACKER_MSB_FIRST_EN
  assign w_slot = c_LANE_LAST - r_lane;
`else
  assign w_slot = r_lane;
`endif

  // Current word with DataIN dropped into the lane selected by the lane index
  always_comb begin
    w_ins_word = r_asm;
    w_ins_keep = r_asm_keep;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (w_slot == c_LANE_W'(i)) begin
        w_ins_word[i*DATA_W +: DATA_W] = DataIN;
        w_ins_keep[i]                  = 1'b1;
      end
    end
  end

  // Capture FSM next-state, lane assembly and FIFO push generation
  always_comb begin
    w_state_nxt     = r_state;
    w_lane_nxt      = r_lane;
    w_asm_nxt       = r_asm;
    w_asm_keep_nxt  = r_asm_keep;
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_word_nxt = r_pend_word;
    w_cap           = 1'b0;
    w_push          = 1'b0;
    w_push_word     = '0;
    w_push_keep     = '0;
    w_push_last     = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Only arm with the strobe low so a frame is never joined mid-way
        if (Enable && !StrobIN) begin
          w_state_nxt = S_ARMED;
        end
      end

      S_ARMED: begin
        if (!Enable) begin
          w_state_nxt = S_IDLE;
        end else if (StrobIN) begin
          w_cap       = 1'b1;
          w_state_nxt = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        if (Enable && StrobIN) begin
          // A full word waiting in pending leaves as soon as the next one starts
          if ((r_lane == '0) && r_pend_vld) begin
            w_push         = 1'b1;
            w_push_word    = r_pend_word;
            w_push_keep    = '1;
            w_push_last    = 1'b0;
            w_pend_vld_nxt = 1'b0;
          end
          w_cap = 1'b1;
        end else begin
          // Frame end (strobe low or capture disabled): flush whatever is held
          if (r_lane != '0) begin
            w_push      = 1'b1;
            w_push_word = r_asm;
            w_push_keep = r_asm_keep;
            w_push_last = 1'b1;
          end else if (r_pend_vld) begin
            w_push      = 1'b1;
            w_push_word = r_pend_word;
            w_push_keep = '1;
            w_push_last = 1'b1;
          end
          w_asm_nxt      = '0;
          w_asm_keep_nxt = '0;
          w_lane_nxt     = '0;
          w_pend_vld_nxt = 1'b0;
          w_state_nxt    = Enable ? S_ARMED : S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Store the sample; a completed word moves to pending and the lanes restart
    if (w_cap) begin
      if (r_lane == c_LANE_LAST) begin
        w_pend_word_nxt = w_ins_word;
        w_pend_vld_nxt  = 1'b1;
        w_asm_nxt       = '0;
        w_asm_keep_nxt  = '0;
        w_lane_nxt      = '0;
      end else begin
        w_asm_nxt      = w_ins_word;
        w_asm_keep_nxt = w_ins_keep;
        w_lane_nxt     = r_lane + 1'b1;
      end
    end
  end

  // Capture state registers
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= S_IDLE;
      r_lane      <= '0;
      r_asm       <= '0;
      r_asm_keep  <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_word <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_lane      <= w_lane_nxt;
      r_asm       <= w_asm_nxt;
      r_asm_keep  <= w_asm_keep_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_word <= w_pend_word_nxt;
    end
  end

  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == c_CNT_W'(FIFO_DEPTH));
  assign w_pop      = w_nonempty && ReadyIN;
  // A push into a full FIFO still fits when the head leaves in the same cycle
  assign w_accept   = w_push && (!w_full || w_pop);
  assign w_drop     = w_push && w_full && !w_pop;

  // FIFO storage; contents are only observed while the entry is counted
  always_ff @(posedge Clock) begin
    if (w_accept) begin
      r_mem_word[r_wr_ptr] <= w_push_word;
      r_mem_keep[r_wr_ptr] <= w_push_keep;
      r_mem_last[r_wr_ptr] <= w_push_last;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_accept && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_accept && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      // A fresh drop outranks a clear in the same cycle
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ClearOvf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign ValidOUT = w_nonempty;
  assign WordOUT  = w_nonempty ? r_mem_word[r_rd_ptr] : '0;
  assign KeepOUT  = w_nonempty ? r_mem_keep[r_rd_ptr] : '0;
  assign LastOUT  = w_nonempty ? r_mem_last[r_rd_ptr] : 1'b0;
  assign Overflow = r_ovf;
  assign Busy     = (r_state != S_IDLE) || w_nonempty;

endmodule
`default_nettype wire

// File: tb/tb_lvds_sample_packer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_lvds_sample_packer
// Purpose  : Self-checking bench for lvds_sample_packer. A frame-level model
//            (byte queue per frame, word queue for the FIFO) predicts the
//            outputs each cycle; directed scenarios add literal expectations.
// Options  : PACKER_MSB_FIRST_EN - literal expectations and model follow it.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_lvds_sample_packer;

  localparam int DW    = 8;
  localparam int WB    = 4;
  localparam int DEPTH = 4;
  localparam int WW    = DW * WB;

  typedef struct packed {
    logic [WW-1:0] w;
    logic [WB-1:0] k;
    logic          l;
  } word_t;

  logic          Clock = 1'b0;
  logic          Reset_n = 1'b0;
  logic          Enable = 1'b0;
  logic [DW-1:0] DataIN = '0;
  logic          StrobIN = 1'b0;
  logic [WW-1:0] WordOUT;
  logic [WB-1:0] KeepOUT;
  logic          LastOUT;
  logic          ValidOUT;
  logic          ReadyIN = 1'b0;
  logic          Overflow;
  logic          ClearOvf = 1'b0;
  logic          Busy;

  int checks = 0;
  int errors = 0;

  lvds_sample_packer #(
    .DATA_W     (DW),
    .WORD_BYTES (WB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Enable   (Enable),
    .DataIN   (DataIN),
    .StrobIN  (StrobIN),
    .WordOUT  (WordOUT),
    .KeepOUT  (KeepOUT),
    .LastOUT  (LastOUT),
    .ValidOUT (ValidOUT),
    .ReadyIN  (ReadyIN),
    .Overflow (Overflow),
    .ClearOvf (ClearOvf),
    .Busy     (Busy)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Literal written in first-sample-in-lane-0 order; mirrored for MSB-first builds
  function automatic word_t lit(input logic [WW-1:0] w, input logic [WB-1:0] k, input logic l);
    word_t r;
    r.l = l;
`ifdef PACKER_MSB_FIRST_EN
    for (int i = 0; i < WB; i++) begin
      r.w[(WB-1-i)*DW +: DW] = w[i*DW +: DW];
      r.k[WB-1-i]            = k[i];
    end
`else
    r.w = w;
    r.k = k;
`endif
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  int            m_mode = 0;     // 0 idle, 1 armed, 2 in frame
  logic [DW-1:0] frame[$];       // bytes of the frame being received
  word_t         fq[$];          // words sitting in the output FIFO
  logic          m_ovf = 1'b0;
  word_t         dut_log[$];     // words the DUT handed to the consumer

  // Word made of n consecutive frame bytes starting at index start
  function automatic word_t make_word(input int start, input int n, input logic last);
    word_t r;
    r = '0;
    r.l = last;
    for (int i = 0; i < n; i++) begin
      int pos;
`ifdef PACKER_MSB_FIRST_EN
      pos = WB - 1 - i;
`else
      pos = i;
`endif
      r.w[pos*DW +: DW] = frame[start + i];
      r.k[pos]          = 1'b1;
    end
    return r;
  endfunction

  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      m_mode = 0;
      frame.delete();
      fq.delete();
      m_ovf = 1'b0;
    end else begin
      bit    have_push;
      bit    pop;
      bit    drop;
      word_t pw;
      int    n;
      have_push = 1'b0;
      drop = 1'b0;
      pw = '0;
      pop = (fq.size() != 0) && ReadyIN;
      case (m_mode)
        0: if (Enable && !StrobIN) m_mode = 1;
        1: begin
          if (!Enable) m_mode = 0;
          else if (StrobIN) begin
            frame.delete();
            frame.push_back(DataIN);
            m_mode = 2;
          end
        end
        default: begin
          if (Enable && StrobIN) begin
            frame.push_back(DataIN);
            n = frame.size();
            // The first byte of each later word releases the previous full word
            if (n > WB && ((n - 1) % WB) == 0) begin
              pw = make_word(n - 1 - WB, WB, 1'b0);
              have_push = 1'b1;
            end
          end else begin
            n = frame.size();
            if ((n % WB) != 0) pw = make_word(n - (n % WB), n % WB, 1'b1);
            else               pw = make_word(n - WB, WB, 1'b1);
            have_push = 1'b1;
            frame.delete();
            m_mode = Enable ? 1 : 0;
          end
        end
      endcase
      if (pop) void'(fq.pop_front());
      if (have_push) begin
        if (fq.size() < DEPTH) fq.push_back(pw);
        else                   drop = 1'b1;
      end
      if (drop)          m_ovf = 1'b1;
      else if (ClearOvf) m_ovf = 1'b0;
    end
  end

  // Overflow rule kept separately: a push finding the FIFO full with no pop
  int   m_occ_before = 0;
  always @(negedge Clock) m_occ_before = fq.size();

  // ---------------- compare process ----------------
  always @(negedge Clock) begin
    if (!Reset_n) begin
      check("rst_valid", ValidOUT, 0);
      check("rst_ovf",   Overflow, 0);
      check("rst_busy",  Busy, 0);
      check("rst_word",  {WordOUT, KeepOUT, LastOUT}, 0);
    end else begin
      check("valid",    ValidOUT, (fq.size() != 0));
      check("overflow", Overflow, m_ovf);
      check("busy",     Busy, (m_mode != 0) || (fq.size() != 0));
      if (fq.size() != 0) check("head", {WordOUT, KeepOUT, LastOUT}, fq[0]);
      if (ValidOUT && ReadyIN) dut_log.push_back({WordOUT, KeepOUT, LastOUT});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic send_bytes(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      DataIN  = DW'(first + i);
      StrobIN = 1'b1;
      tick();
    end
  endtask

  task automatic end_frame();
    StrobIN = 1'b0;
    DataIN  = '0;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    idle(3);
    Reset_n = 1'b1;

    // 1: two full words from eight bytes
    Enable = 1'b1; ReadyIN = 1'b1;
    tick();
    dut_log.delete();
    send_bytes(8'h01, 8); end_frame(); idle(4);
    check("t1_count", dut_log.size(), 2);
    check("t1_w0", dut_log[0], lit(32'h04030201, 4'hF, 1'b0));
    check("t1_w1", dut_log[1], lit(32'h08070605, 4'hF, 1'b1));
    check("t1_ovf", Overflow, 0);

    // 2: full word then a two-byte partial
    dut_log.delete();
    send_bytes(8'h01, 6); end_frame(); idle(4);
    check("t2_count", dut_log.size(), 2);
    check("t2_w0", dut_log[0], lit(32'h04030201, 4'hF, 1'b0));
    check("t2_w1", dut_log[1], lit(32'h00000605, 4'h3, 1'b1));

    // 3: enable raised mid-frame; that frame is ignored
    Enable = 1'b0; idle(2);
    dut_log.delete();
    DataIN = 8'hAA; StrobIN = 1'b1; tick();
    Enable = 1'b1;
    send_bytes(8'hAB, 3); end_frame();
    send_bytes(8'h11, 4); end_frame(); idle(4);
    check("t3_count", dut_log.size(), 1);
    check("t3_w0", dut_log[0], lit(32'h14131211, 4'hF, 1'b1));

    // 4: back-pressure, fifth word dropped
    ReadyIN = 1'b0;
    dut_log.delete();
    for (int f = 0; f < 5; f++) begin
      send_bytes(DW'(8'h40 + 4*f), 4); end_frame();
    end
    idle(1);
    check("t4_ovf_set", Overflow, 1);
    check("t4_valid", ValidOUT, 1);
    ReadyIN = 1'b1; idle(6);
    check("t4_count", dut_log.size(), 4);
    check("t4_first", dut_log[0], lit(32'h43424140, 4'hF, 1'b1));
    check("t4_fourth", dut_log[3], lit(32'h4F4E4D4C, 4'hF, 1'b1));
    ClearOvf = 1'b1; tick(); ClearOvf = 1'b0;
    check("t4_ovf_clr", Overflow, 0);

    // 5: enable dropped after three bytes
    dut_log.delete();
    send_bytes(8'h21, 3);
    Enable = 1'b0; DataIN = 8'h24; StrobIN = 1'b1; tick();
    StrobIN = 1'b0; idle(4);
    check("t5_count", dut_log.size(), 1);
    check("t5_w0", dut_log[0], lit(32'h00232221, 4'h7, 1'b1));
    check("t5_busy", Busy, 0);

    // 6: reset mid-frame with two words queued
    Enable = 1'b1; ReadyIN = 1'b0; tick();
    send_bytes(8'h50, 4); end_frame();
    send_bytes(8'h54, 4); end_frame();
    send_bytes(8'h58, 2);
    check("t6_queued", ValidOUT, 1);
    #2 Reset_n = 1'b0;
    #1;
    check("t6_valid", ValidOUT, 0);
    check("t6_busy", Busy, 0);
    @(posedge Clock); #1 Reset_n = 1'b1;
    StrobIN = 1'b0; ReadyIN = 1'b1; tick();
    dut_log.delete();
    send_bytes(8'h31, 4); end_frame(); idle(4);
    check("t6_count", dut_log.size(), 1);
    check("t6_w0", dut_log[0], lit(32'h34333231, 4'hF, 1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lvds_sample_packer.md
Name: lvds_sample_packer

Overview:
- Sits directly downstream of the LVDS differential receiver and runs on the receiver's recovered clock.
- Consumes the receiver's registered byte stream and its strobe.
- Groups strobed bytes into 32-bit words with a byte-keep mask and an end-of-frame flag.
- Buffers the words in a small FIFO with a valid/ready interface for the capture/readout logic.

Parameters:
DATA_W, 8, width of one received sample (matches receiver data width)
WORD_BYTES, 4, samples packed per output word
FIFO_DEPTH, 4, output FIFO entries; power of 2, at least 2

Ports:
Clock  in  1  recovered receiver clock; all logic on its rising edge
Reset_n  in  1  asynchronous active-low reset
Enable  in  1  capture enable
DataIN  in  DATA_W  sample from receiver
StrobIN  in  1  sample-valid / frame-active from receiver
WordOUT  out  DATA_W*WORD_BYTES  FIFO head word
KeepOUT  out  WORD_BYTES  per-lane valid mask of head word
LastOUT  out  1  head word ends a frame
ValidOUT  out  1  FIFO non-empty
ReadyIN  in  1  consumer accepts head word
Overflow  out  1  sticky: a word was dropped
ClearOvf  in  1  clears Overflow
Busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (async, Reset_n=0):
  - State IDLE; lane index 0; pending register empty; FIFO empty.
  - ValidOUT, Overflow, Busy, LastOUT = 0; KeepOUT = 0; WordOUT = 0.
- States:
  - IDLE: on Enable=1 and StrobIN=0, go to ARMED. If StrobIN=1, wait; a frame is never joined mid-way.
  - ARMED:
    - Enable=0: go to IDLE.
    - StrobIN=1: store DataIN in lane 0, lane=1, go to CAPTURE.
  - CAPTURE, on each StrobIN=1 cycle:
    - Store DataIN in the current lane and increment the lane.
    - When lane WORD_BYTES-1 is filled, move the assembled word to the pending register (keep all ones) and wrap lane to 0.
    - If the pending register is full when a byte enters lane 0, push pending with Last=0.
  - Frame end, on StrobIN=0 in CAPTURE:
    - lane>0: push the partial word. Unfilled lanes are 0. Keep has bits set for the filled lanes only. Last=1.
    - lane=0: push the pending word with Last=1.
    - Pending and partial never coexist at frame end.
    - Then go to ARMED if Enable=1, else IDLE.
  - Enable=0 during CAPTURE: treated exactly as frame end in that cycle; DataIN is not captured; then go to IDLE.
- Push rate: at most one FIFO push per cycle.
- Latency:
  - The pending word is pushed on the edge sampling the next byte or the frame end.
  - ValidOUT asserts the cycle after the push.
- FIFO:
  - Pop when ValidOUT and ReadyIN.
  - Push when full without a pop: word dropped, Overflow=1.
  - Push when full with a simultaneous pop: accepted.
  - Pointers wrap modulo FIFO_DEPTH; the count is DATA_W-independent.
- Overflow: sticky. ClearOvf clears it next cycle; a new overflow in the same cycle as ClearOvf wins, so Overflow stays 1.
- Outputs: WordOUT, KeepOUT and LastOUT are stable while ValidOUT=1 and ReadyIN=0.
- Reset mid-frame: all state discarded immediately. After release, capture resumes only via IDLE → ARMED with the strobe low.

Optional Feature:
PACKER_MSB_FIRST_EN
- Defined: the first sample of a word goes to the top lane (WordOUT[31:24] at defaults). KeepOUT bit order mirrors the lanes, so a 2-byte partial gives keep 0xC.
- Undefined (default): the first sample goes to lane 0 (WordOUT[7:0]); the 2-byte partial gives keep 0x3.

Test Plan:
1. Enable=1, ReadyIN=1, strobe 8 bytes 0x01..0x08, then strobe low → 0x04030201 keep 0xF last 0, then 0x08070605 keep 0xF last 1; Overflow 0.
2. Strobe 6 bytes 0x01..0x06 → 0x04030201 keep 0xF last 0, then 0x00000605 keep 0x3 last 1 (with MSB_FIRST_EN: 0x01020304, then 0x05060000 keep 0xC).
3. Enable raised while StrobIN=1 mid-frame (bytes 0xAA..) → no words for that frame; the next frame 0x11..0x14 gives 0x14131211 last 1.
4. ReadyIN=0, five 4-byte frames, FIFO_DEPTH=4 → four words held, Overflow=1, fifth dropped. Raise ReadyIN: exactly four words drain, first frame first. ClearOvf → Overflow 0.
5. Enable dropped after 3 strobed bytes 0x21,0x22,0x23 → 0x00232221 keep 0x7 last 1; state IDLE; Busy 0 after drain.
6. Reset_n pulsed low mid-frame with 2 words queued → ValidOUT 0 and Busy 0 immediately. After release, a clean frame 0x31..0x34 gives 0x34333231 last 1.
